// File: rtl/note_sequencer.sv
// Song ROM walker feeding note_player: fetches {note, duration, weight} entries and
// holds each for its duration in beats. note_done is registered (high the cycle after the expiring beat).
module note_sequencer #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5,
  parameter int DUR_BITS  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play_enable,
  input  logic                          restart,
  input  logic [SONG_BITS-1:0]          song_sel,
  input  logic                          beat,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [13:0]                   rom_data,
  output logic [5:0]                    note_to_load,
  output logic [1:0]                    weight,
  output logic                          load_new_note,
  output logic                          note_done,
  output logic                          song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [SONG_BITS-1:0] song_q, song_next;
  logic [IDX_BITS-1:0]  idx, idx_next;
  logic [DUR_BITS-1:0]  beat_cnt, dur_q, cnt_inc, rom_dur;
  logic [5:0]           rom_note;
  logic                 counted, hold_expire, last_idx;

  assign rom_note    = rom_data[13:8];
  assign rom_dur     = rom_data[2 +: DUR_BITS];
  assign counted     = (state == S_HOLD) && beat && play_enable;
  assign cnt_inc     = beat_cnt + DUR_BITS'(1);
  assign hold_expire = counted && (cnt_inc == dur_q);
  assign last_idx    = (idx == '1);

  always_comb begin
    next_state = state;
    song_next  = song_q;
    idx_next   = idx;
    if (restart) begin
      next_state = S_FETCH;
      song_next  = song_sel;
      idx_next   = '0;
    end else begin
      case (state)
        S_IDLE:  next_state = S_IDLE;
        S_FETCH: next_state = S_WAIT;
        S_WAIT:  next_state = S_LOAD;
        S_LOAD:  next_state = (dur_q == '0) ? S_DONE : S_HOLD;
        S_HOLD: begin
          if (hold_expire) begin
            if (last_idx) begin
              next_state = S_DONE;
            end else begin
              next_state = S_FETCH;
              idx_next   = idx + IDX_BITS'(1);
            end
          end
        end
        S_DONE:  next_state = S_DONE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      song_q        <= '0;
      idx           <= '0;
      beat_cnt      <= '0;
      dur_q         <= '0;
      rom_addr      <= '0;
      note_to_load  <= '0;
      weight        <= '0;
      load_new_note <= 1'b0;
      note_done     <= 1'b0;
      song_done     <= 1'b0;
    end else begin
      state         <= next_state;
      song_q        <= song_next;
      idx           <= idx_next;
      load_new_note <= 1'b0;
      note_done     <= hold_expire && !restart;
      song_done     <= (next_state == S_DONE);

      if (next_state == S_FETCH)
        rom_addr <= {song_next, idx_next};

      if (restart || hold_expire)
        beat_cnt <= '0;
      else if (counted)
        beat_cnt <= cnt_inc;

      // The load pulse is registered off the WAIT-cycle ROM word so it lands in the LOAD cycle.
      if (state == S_WAIT && !restart) begin
        dur_q <= rom_dur;
        if (rom_note != '0 && rom_dur != '0) begin
          load_new_note <= 1'b1;
          note_to_load  <= rom_note;
          weight        <= rom_data[1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a song-level model lists the expected load / note_done /
// song_done events; a negedge monitor pops and compares them, including beat counts and fetch latency.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play_enable = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] song_sel = '0;
  logic       beat = 1'b0;
  logic [6:0] rom_addr;
  logic [13:0] rom_data;
  logic [5:0] note_to_load;
  logic [1:0] weight;
  logic       load_new_note, note_done, song_done;

  note_sequencer #(.SONG_BITS(2), .IDX_BITS(5), .DUR_BITS(6)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .restart(restart),
    .song_sel(song_sel), .beat(beat), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_to_load(note_to_load), .weight(weight), .load_new_note(load_new_note),
    .note_done(note_done), .song_done(song_done)
  );

  always #5 clk = ~clk;

  logic [13:0] rom [0:127];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // kind: 0 = load, 1 = note_done, 2 = song_done
  typedef struct {
    int         kind;
    logic [5:0] note;
    logic [1:0] wt;
    logic [6:0] addr;
    int         dur;
  } ev_t;

  ev_t        sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [5:0] mdl_note = '0;
  logic [1:0] mdl_wt = '0;
  logic [6:0] last_addr = '0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [13:0] ent(input int n, input int d, input int w);
    logic [5:0] nn;
    logic [5:0] dd;
    logic [1:0] ww;
    nn = n[5:0];
    dd = d[5:0];
    ww = w[1:0];
    return {nn, dd, ww};
  endfunction

  function automatic void push_ev(input int kind, input logic [6:0] addr, input int dur);
    ev_t ev;
    ev.kind = kind;
    ev.note = mdl_note;
    ev.wt   = mdl_wt;
    ev.addr = addr;
    ev.dur  = dur;
    sb_q.push_back(ev);
    last_addr = addr;
  endfunction

  // Song-level reference: walk the entries and list the events a listener would see.
  function automatic void build(input int s);
    for (int i = 0; i < 32; i++) begin
      logic [13:0] e;
      int          n;
      int          d;
      logic [6:0]  a_cur;
      logic [6:0]  a_nxt;
      e     = rom[s*32 + i];
      n     = int'(e[13:8]);
      d     = int'(e[7:2]);
      a_cur = 7'(s*32 + i);
      a_nxt = (i == 31) ? a_cur : 7'(s*32 + i + 1);
      if (d == 0) begin
        push_ev(2, a_cur, 0);
        return;
      end
      if (n != 0) begin
        mdl_note = e[13:8];
        mdl_wt   = e[1:0];
        push_ev(0, a_cur, 0);
      end
      push_ev(1, a_nxt, d);
      if (i == 31) push_ev(2, a_cur, 0);
    end
  endfunction

  task automatic take(input string kname, input int kind, output ev_t ev, output bit ok);
    n_cmp++;
    ok = 1'b0;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got an output event, expected none pending", kname);
    end else begin
      ev = sb_q.pop_front();
      if (ev.kind != kind) begin
        n_fail++;
        $display("FAIL %s: got event kind %0d, expected kind %0d", kname, kind, ev.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor
  int cyc = 0;
  int fetch_cyc = -100;
  int win_start = 1 << 30;
  int bcnt = 0;
  logic prev_sd = 1'b0;

  always @(negedge clk) begin : mon
    ev_t ev;
    bit  ok;
    cyc++;
    if (!reset) begin
      fetch_cyc = -100;
      win_start = 1 << 30;
      bcnt      = 0;
      prev_sd   = 1'b0;
    end else begin
      if (load_new_note) begin
        take("load", 0, ev, ok);
        if (ok) begin
          check("load_note", note_to_load, ev.note);
          check("load_weight", weight, ev.wt);
          check("load_addr", rom_addr, ev.addr);
          check("load_latency", cyc - fetch_cyc, 2);
        end
      end
      if (note_done) begin
        take("note_done", 1, ev, ok);
        if (ok) begin
          check("done_beats", bcnt, ev.dur);
          check("done_note_held", note_to_load, ev.note);
          check("done_weight_held", weight, ev.wt);
          check("done_addr", rom_addr, ev.addr);
        end
        fetch_cyc = cyc;
        win_start = cyc + 3;
        bcnt      = 0;
      end
      if (song_done && !prev_sd) begin
        take("song_done", 2, ev, ok);
        if (ok) begin
          check("sdone_addr", rom_addr, ev.addr);
          check("sdone_note", note_to_load, ev.note);
        end
      end
      prev_sd = song_done;
      if (restart) begin
        fetch_cyc = cyc + 1;
        win_start = cyc + 4;
        bcnt      = 0;
      end else if (cyc >= win_start && beat && play_enable) begin
        bcnt++;
      end
    end
  end

  task automatic step(input bit b, input bit pe, input bit rs);
    @(posedge clk);
    #1;
    beat        = b;
    play_enable = pe;
    restart     = rs;
  endtask

  task automatic launch(input int s, input bit b);
    song_sel = 2'(s);
    step(b, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("fetch_addr", rom_addr, s*32);
  endtask

  task automatic complete(input int s);
    for (int k = 0; k < 4000; k++) begin
      if (sb_q.size() == 0) break;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL song%0d_timeout: got %0d events pending, expected 0", s, sb_q.size());
      sb_q.delete();
    end
    repeat (6) step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("song_done_held", song_done, 1);
    check("done_addr_held", rom_addr, last_addr);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 14'($urandom);
    // song 0: random with rests, terminated
    begin
      int len;
      len = $urandom_range(6, 12);
      for (int i = 0; i < len; i++)
        rom[i] = ent(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63),
                     $urandom_range(1, 4), $urandom_range(0, 3));
      rom[len] = ent($urandom_range(0, 63), 0, $urandom_range(0, 3));
    end
    rom[32] = ent(1, 2, 0);
    rom[33] = ent(22, 1, 2);
    rom[34] = ent(0, 0, 0);
    rom[64] = ent(5, 1, 1);
    rom[65] = ent(0, 3, 3);
    rom[66] = ent(9, 4, 1);
    rom[67] = ent(0, 0, 0);
    for (int i = 0; i < 32; i++) rom[96 + i] = ent($urandom_range(0, 63), 1, $urandom_range(0, 3));

    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr", rom_addr, 0);
    check("rst_note", note_to_load, 0);
    check("rst_weight", weight, 0);
    check("rst_load", load_new_note, 0);
    check("rst_note_done", note_done, 0);
    check("rst_song_done", song_done, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // song 1 and the rest/pause song
    build(1); launch(1, 1'b0); complete(1);
    build(2); launch(2, 1'b0); complete(2);

    // restart on the final beat of a note
    build(1); launch(1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    sb_q.delete();
    mdl_note = 6'd1;
    mdl_wt   = 2'd0;
    build(0); launch(0, 1'b1); complete(0);

    // 32 entries, no terminator
    build(3); launch(3, 1'b0); complete(3);
    check("no_wrap_addr", rom_addr, 7'h7f);

    // reset in HOLD
    build(2); launch(2, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_addr", rom_addr, 0);
    check("midrst_note", note_to_load, 0);
    check("midrst_weight", weight, 0);
    check("midrst_load", load_new_note, 0);
    check("midrst_song_done", song_done, 0);
    mdl_note = '0;
    mdl_wt   = '0;
    build(2); launch(2, 1'b0); complete(2);

    repeat (3) begin
      int s;
      s = $urandom_range(0, 3);
      build(s); launch(s, 1'b0); complete(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
